// File: rtl/keypad_digit_accumulator.sv
// Turns scanner hits into one event per keypress and edits a right-justified BCD entry buffer (0-9, B, C, A).
// Outputs are one cycle after the qualifying edge; a submitted number holds num_valid/bcd/count until num_ready.
module keypad_digit_accumulator #(
  parameter int N_DIGITS       = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            code,
  input  logic                  valido,
  input  logic                  num_ready,
  output logic                  num_valid,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic [3:0]            count,
  output logic                  key_pulse,
  output logic                  err
);

  localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [3:0]    NDIG     = 4'(N_DIGITS);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_RELEASE = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
  logic [3:0]              count_q, count_d;
  logic [RW-1:0]           rel_cnt_q, rel_cnt_d;
  logic                    num_valid_q, num_valid_d;
  logic                    key_pulse_q, key_pulse_d;
  logic                    err_q, err_d;

  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    count_d     = count_q;
    rel_cnt_d   = rel_cnt_q;
    num_valid_d = num_valid_q;
    key_pulse_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (valido) begin
          key_pulse_d = 1'b1;
          state_d     = S_RELEASE;
          rel_cnt_d   = '0;
          // Unknown codes fall through every branch and behave like D.
          if (code <= 4'd9) begin
            if (count_q < NDIG) begin
              bcd_d      = bcd_q << 4;
              bcd_d[3:0] = code;
              count_d    = count_q + 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (code == 4'hB) begin
            if (count_q != 4'd0) begin
              bcd_d   = bcd_q >> 4;
              count_d = count_q - 4'd1;
            end
          end else if (code == 4'hC) begin
            bcd_d   = '0;
            count_d = 4'd0;
          end else if (code == 4'hA) begin
            if (count_q != 4'd0) begin
              state_d     = S_OUT;
              num_valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      S_RELEASE: begin
        // Any scanner hit restarts the quiet window, so held or bouncing keys act once.
        if (valido) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q == REL_LAST) begin
          rel_cnt_d = '0;
          state_d   = S_WAIT;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end

      S_OUT: begin
        if (num_ready) begin
          bcd_d       = '0;
          count_d     = 4'd0;
          num_valid_d = 1'b0;
          rel_cnt_d   = '0;
          state_d     = S_RELEASE;
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_WAIT;
      bcd_q       <= '0;
      count_q     <= 4'd0;
      rel_cnt_q   <= '0;
      num_valid_q <= 1'b0;
      key_pulse_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      rel_cnt_q   <= rel_cnt_d;
      num_valid_q <= num_valid_d;
      key_pulse_q <= key_pulse_d;
      err_q       <= err_d;
    end
  end

  assign num_valid = num_valid_q;
  assign bcd       = bcd_q;
  assign count     = count_q;
  assign key_pulse = key_pulse_q;
  assign err       = err_q;

endmodule
